bin_clock_timekeeper: RTL and testbench
=======================================

Name: bin_clock_timekeeper

Overview:
- Time-of-day core for the binary clock; sits directly upstream of the top-level pin-mapping stage.
- Divides `clk` down to a 1 Hz tick and keeps hours, minutes and seconds as binary counters.
- Provides a two-button set mode (mode / increment).
- The top level packs `hours`, `minutes`, `seconds` and the status bits onto `uo_out`/`uio_out` for the LED columns.

Parameters:
- CLK_HZ, 10000000, input clock frequency; prescaler period in cycles (must be >= 2).
- SYNC_STAGES, 2, flip-flop stages on each button input before edge detection (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- ena  input  1  global enable; low freezes all state updates
- btn_mode  input  1  mode button, asynchronous, already debounced upstream
- btn_inc  input  1  increment button, asynchronous, already debounced upstream
- hours  output  5  hour value (0-23, or 1-12 with the optional feature)
- minutes  output  6  minute value 0-59
- seconds  output  6  second value 0-59
- sec_tick  output  1  one-cycle pulse on each second boundary in RUN
- mode  output  2  00 = RUN, 01 = SET_HOUR, 10 = SET_MIN; 11 is never produced
- pm  output  1  afternoon flag (optional feature only; otherwise tied to 0)

Behaviour:
- Reset (rst = 1 at a clk edge):
  - hours, minutes, seconds, prescaler, sync flops, edge-detect history and sec_tick go to 0.
  - mode goes to RUN.
  - pm is 0; with the optional feature, hours reads 12.
  - Reset wins over every other input, including mid-set and mid-carry.
- All outputs are registered. No combinational path from any input to any output.
- Button path:
  - SYNC_STAGES flops, then a rising-edge detector.
  - An event takes effect on the edge SYNC_STAGES+1 cycles after the input rises (3 cycles at default).
  - A held button produces exactly one event.
- ena = 0:
  - Prescaler, counters, mode and sec_tick are held; sec_tick is forced to 0.
  - Sync flops and edge history keep sampling, so a press made while disabled is not replayed when ena returns.
- FSM, advanced on btn_mode events: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - A btn_mode event and a btn_inc event in the same cycle: the mode step wins and inc is dropped.
- RUN:
  - Prescaler counts 0..CLK_HZ-1.
  - On the cycle it holds CLK_HZ-1: it wraps to 0, sec_tick = 1 for the next cycle, and seconds increment on that same edge.
  - Carry chain within one edge: seconds 59 -> 0 increments minutes; minutes 59 -> 0 increments hours; hours 23 -> 0.
  - 23:59:59 -> 00:00:00 in one edge.
  - btn_inc is ignored.
- SET_HOUR:
  - btn_inc increments hours with wrap 23 -> 0, with no carry to other fields.
  - Prescaler and seconds are held at 0.
- SET_MIN:
  - btn_inc increments minutes with wrap 59 -> 0, with no carry into hours.
  - Prescaler and seconds are held at 0.
- Leaving SET_MIN for RUN:
  - Counting restarts from prescaler 0.
  - The first sec_tick comes CLK_HZ cycles after the mode change.
- Counter values are never out of range. Widths are fixed: 5 bits for hours, 6 for minutes and seconds.

Optional Feature:
- Macro: BIN_CLOCK_12H_EN.
- Defined:
  - The internal hour counter stays 0-23.
  - hours output = 12 when internal = 0; internal - 12 when internal > 12; otherwise internal.
  - pm = 1 when internal >= 12.
  - All output logic is registered, with the same timing as the other outputs.
- Not defined:
  - hours = internal 0-23.
  - pm is a constant 0 (port still present).

Test Plan (CLK_HZ = 4, SYNC_STAGES = 2):
- Reset, then run 4 cycles -> sec_tick pulses once; seconds = 1. After 240 cycles -> minutes = 1, seconds = 0.
- Set mode to reach 23:59 via SET_HOUR/SET_MIN inc presses, then return to RUN; wait 60 ticks -> hours = 0, minutes = 0, seconds = 0, with the full carry on a single edge.
- Hold btn_inc high 10 cycles in SET_HOUR from 0 -> hours = 1 (one event), appearing 3 cycles after the rise.
- Assert btn_mode and btn_inc rising together in SET_HOUR -> mode = SET_MIN; hours unchanged.
- In RUN at prescaler = 2, drop ena for 20 cycles while pulsing btn_mode -> no tick, mode stays RUN. After ena returns, the tick arrives 2 cycles later.
- With BIN_CLOCK_12H_EN:
  - internal 0 -> hours = 12, pm = 0
  - internal 13 -> hours = 1, pm = 1
  - internal 12 -> hours = 12, pm = 1
- Assert rst during SET_MIN with minutes = 37 -> next edge: all counters 0, mode = RUN, sec_tick = 0.

Source files
------------

// File: rtl/bin_clock_timekeeper.sv
// Time-of-day core: 1 Hz prescaler, binary h/m/s counters and a two-button set mode.
// Optional 12-hour display with pm flag when BIN_CLOCK_12H_EN is defined.
module bin_clock_timekeeper #(
  parameter int CLK_HZ      = 10000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       sec_tick,
  output logic [1:0] mode,
  output logic       pm
);

  localparam int PW = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t                 state_r, state_s;
  logic [PW-1:0]          presc_r, presc_s;
  logic [4:0]             hour_r, hour_s;
  logic [5:0]             min_r, min_s;
  logic [5:0]             sec_r, sec_s;
  logic                   tick_r, tick_s;
  logic [4:0]             hours_r;
  logic                   pm_r, pm_s;
  logic [SYNC_STAGES-1:0] mode_sync_r, inc_sync_r;
  logic                   mode_hist_r, inc_hist_r;
  logic                   mode_ev_s, inc_ev_s;

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    if (v >= 6'd59) begin
      return 6'd0;
    end else begin
      return v + 6'd1;
    end
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    if (v >= 5'd23) begin
      return 5'd0;
    end else begin
      return v + 5'd1;
    end
  endfunction

  function automatic logic [4:0] to_display(input logic [4:0] h);
`ifdef BIN_CLOCK_12H_EN
    if (h == 5'd0) begin
      return 5'd12;
    end else if (h > 5'd12) begin
      return h - 5'd12;
    end else begin
      return h;
    end
`else
    return h;
`endif
  endfunction

`ifdef BIN_CLOCK_12H_EN
  assign pm_s = (hour_s >= 5'd12);
`else
  assign pm_s = 1'b0;
`endif

  assign mode_ev_s = mode_sync_r[SYNC_STAGES-1] & ~mode_hist_r;
  assign inc_ev_s  = inc_sync_r[SYNC_STAGES-1] & ~inc_hist_r;

  // Next-state: mode sequencing, prescaler and the full carry chain in one edge
  always_comb begin
    state_s = state_r;
    presc_s = presc_r;
    hour_s  = hour_r;
    min_s   = min_r;
    sec_s   = sec_r;
    tick_s  = 1'b0;
    if (ena) begin
      case (state_r)
        RUN: begin
          if (mode_ev_s) begin
            state_s = SET_HOUR;
            presc_s = '0;
            sec_s   = 6'd0;
          end else if (presc_r == PRESC_MAX) begin
            presc_s = '0;
            tick_s  = 1'b1;
            sec_s   = inc_mod60(sec_r);
            if (sec_r == 6'd59) begin
              min_s = inc_mod60(min_r);
              if (min_r == 6'd59) begin
                hour_s = inc_hour(hour_r);
              end else begin
                hour_s = hour_r;
              end
            end else begin
              min_s = min_r;
            end
          end else begin
            presc_s = presc_r + PRESC_ONE;
          end
        end
        SET_HOUR: begin
          presc_s = '0;
          sec_s   = 6'd0;
          // a simultaneous mode step takes priority and drops the increment
          if (mode_ev_s) begin
            state_s = SET_MIN;
          end else if (inc_ev_s) begin
            hour_s = inc_hour(hour_r);
          end else begin
            hour_s = hour_r;
          end
        end
        SET_MIN: begin
          presc_s = '0;
          sec_s   = 6'd0;
          if (mode_ev_s) begin
            state_s = RUN;
          end else if (inc_ev_s) begin
            min_s = inc_mod60(min_r);
          end else begin
            min_s = min_r;
          end
        end
        default: begin
          state_s = RUN;
          presc_s = '0;
          sec_s   = 6'd0;
        end
      endcase
    end else begin
      tick_s = 1'b0;
    end
  end

  // State and output registers; button synchronisers keep sampling even when disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_sync_r <= '0;
      inc_sync_r  <= '0;
      mode_hist_r <= 1'b0;
      inc_hist_r  <= 1'b0;
      state_r     <= RUN;
      presc_r     <= '0;
      hour_r      <= 5'd0;
      min_r       <= 6'd0;
      sec_r       <= 6'd0;
      tick_r      <= 1'b0;
      hours_r     <= to_display(5'd0);
      pm_r        <= 1'b0;
    end else begin
      mode_sync_r <= {mode_sync_r[SYNC_STAGES-2:0], btn_mode};
      inc_sync_r  <= {inc_sync_r[SYNC_STAGES-2:0], btn_inc};
      mode_hist_r <= mode_sync_r[SYNC_STAGES-1];
      inc_hist_r  <= inc_sync_r[SYNC_STAGES-1];
      state_r     <= state_s;
      presc_r     <= presc_s;
      hour_r      <= hour_s;
      min_r       <= min_s;
      sec_r       <= sec_s;
      tick_r      <= tick_s;
      hours_r     <= to_display(hour_s);
      pm_r        <= pm_s;
    end
  end

  assign hours    = hours_r;
  assign minutes  = min_r;
  assign seconds  = sec_r;
  assign sec_tick = tick_r;
  assign mode     = state_r;
  assign pm       = pm_r;

endmodule

// File: tb/tb_bin_clock_timekeeper.sv
// Bench for bin_clock_timekeeper: vector table, directed corner sequences and
// randomized traffic against a seconds-of-day reference model.
module tb_bin_clock_timekeeper;

  localparam int CLK_HZ = 4;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       sec_tick;
  logic [1:0] mode;
  logic       pm;

  bin_clock_timekeeper #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .ena(ena), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hours(hours), .minutes(minutes), .seconds(seconds),
    .sec_tick(sec_tick), .mode(mode), .pm(pm)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: time of day as a seconds count, plus raw button sample history
  int          m_mode  = 0;
  int          m_tod   = 0;
  int          m_phase = 0;
  int          m_tick  = 0;
  logic [SYNC:0] sh_m = '0;
  logic [SYNC:0] sh_i = '0;

  function automatic int disp_hour(input int h);
`ifdef BIN_CLOCK_12H_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
`else
    return h;
`endif
  endfunction

  function automatic int exp_pm(input int h);
`ifdef BIN_CLOCK_12H_EN
    return (h >= 12) ? 1 : 0;
`else
    return (h < 0) ? 1 : 0;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit bm, input bit bi);
    bit ev_m, ev_i;
    int h, mi;
    if (r) begin
      m_mode = 0; m_tod = 0; m_phase = 0; m_tick = 0;
      sh_m = '0; sh_i = '0;
      return;
    end
    ev_m = sh_m[SYNC-1] && !sh_m[SYNC];
    ev_i = sh_i[SYNC-1] && !sh_i[SYNC];
    sh_m = {sh_m[SYNC-1:0], bm};
    sh_i = {sh_i[SYNC-1:0], bi};
    m_tick = 0;
    if (e) begin
      h  = m_tod / 3600;
      mi = (m_tod / 60) % 60;
      if (ev_m) begin
        if (m_mode == 0) begin
          m_tod   = m_tod - (m_tod % 60);
          m_phase = 0;
        end
        m_mode = (m_mode + 1) % 3;
      end else if (m_mode == 0) begin
        if (m_phase == CLK_HZ - 1) begin
          m_phase = 0;
          m_tod   = (m_tod + 1) % 86400;
          m_tick  = 1;
        end else begin
          m_phase++;
        end
      end else if (ev_i && m_mode == 1) begin
        m_tod = ((h + 1) % 24) * 3600 + mi * 60;
      end else if (ev_i) begin
        m_tod = h * 3600 + ((mi + 1) % 60) * 60;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit e, input bit bm, input bit bi);
    rst = r; ena = e; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_edge(r, e, bm, bi);
    @(negedge clk);
    chk("model_hours",   int'(hours),    disp_hour(m_tod / 3600));
    chk("model_minutes", int'(minutes),  (m_tod / 60) % 60);
    chk("model_seconds", int'(seconds),  m_tod % 60);
    chk("model_tick",    int'(sec_tick), m_tick);
    chk("model_mode",    int'(mode),     m_mode);
    chk("model_pm",      int'(pm),       exp_pm(m_tod / 3600));
  endtask

  task automatic press(input bit bm, input bit bi);
    cyc(1'b0, 1'b1, bm, bi);
    cyc(1'b0, 1'b1, bm, bi);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit r, e, bm, bi;
    int h, mi, s, t, md;
  } vec_t;

  vec_t tv[18];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, guard, ph, pmi, ps;
    bit got, rbm, rbi, rr, re;

    tv[0]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[1]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[3]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tv[4]  = '{0, 1, 0, 0, 0, 0, 1, 1, 0};
    tv[5]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    tv[7]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tv[8]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0};
    tv[9]  = '{0, 1, 0, 0, 0, 0, 2, 1, 0};
    tv[10] = '{0, 1, 1, 0, 0, 0, 2, 0, 0};
    tv[11] = '{0, 1, 1, 0, 0, 0, 2, 0, 0};
    tv[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tv[13] = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
    tv[14] = '{0, 1, 0, 1, 0, 0, 0, 0, 1};
    tv[15] = '{0, 1, 0, 1, 1, 0, 0, 0, 1};
    tv[16] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};
    tv[17] = '{0, 1, 0, 0, 1, 0, 0, 0, 1};

    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].r, tv[i].e, tv[i].bm, tv[i].bi);
      chk($sformatf("vec%0d_hours", i),   int'(hours),    disp_hour(tv[i].h));
      chk($sformatf("vec%0d_minutes", i), int'(minutes),  tv[i].mi);
      chk($sformatf("vec%0d_seconds", i), int'(seconds),  tv[i].s);
      chk($sformatf("vec%0d_tick", i),    int'(sec_tick), tv[i].t);
      chk($sformatf("vec%0d_mode", i),    int'(mode),     tv[i].md);
      chk($sformatf("vec%0d_pm", i),      int'(pm),       exp_pm(tv[i].h));
    end

    // one minute of run time
    cyc(1, 1, 0, 0);
    repeat (239) cyc(0, 1, 0, 0);
    chk("minute_pre_min", int'(minutes), 0);
    chk("minute_pre_sec", int'(seconds), 59);
    cyc(0, 1, 0, 0);
    chk("minute_min", int'(minutes), 1);
    chk("minute_sec", int'(seconds), 0);

    // set 23:59 and roll over the day
    cyc(1, 1, 0, 0);
    press(1, 0);
    repeat (23) press(0, 1);
    chk("set_hour_23", int'(hours), disp_hour(23));
    chk("set_hour_mode", int'(mode), 1);
    press(1, 0);
    repeat (59) press(0, 1);
    chk("set_min_59", int'(minutes), 59);
    chk("set_min_hours", int'(hours), disp_hour(23));
    chk("set_min_mode", int'(mode), 2);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 1, 0);
    cyc(0, 1, 0, 0);
    chk("back_to_run", int'(mode), 0);
    n = 0; got = 0;
    for (int k = 0; k < 12 && !got; k++) begin
      cyc(0, 1, 0, 0);
      n++;
      if (sec_tick) got = 1;
    end
    chk("first_tick_delay", n, CLK_HZ);
    cnt = got ? 1 : 0; guard = 0;
    ph = 0; pmi = 0; ps = 0;
    while (cnt < 60 && guard < 400) begin
      ph = int'(hours); pmi = int'(minutes); ps = int'(seconds);
      cyc(0, 1, 0, 0);
      if (sec_tick) cnt++;
      guard++;
    end
    chk("rollover_ticks", cnt, 60);
    chk("rollover_prev_h", ph, disp_hour(23));
    chk("rollover_prev_m", pmi, 59);
    chk("rollover_prev_s", ps, 59);
    chk("rollover_h", int'(hours), disp_hour(0));
    chk("rollover_m", int'(minutes), 0);
    chk("rollover_s", int'(seconds), 0);

    // held increment yields exactly one event, three edges after the rise
    cyc(1, 1, 0, 0);
    press(1, 0);
    for (int k = 1; k <= 10; k++) begin
      cyc(0, 1, 0, 1);
      chk($sformatf("held_inc_c%0d", k), int'(hours), disp_hour((k >= 3) ? 1 : 0));
    end
    repeat (3) cyc(0, 1, 0, 0);
    chk("held_inc_final", int'(hours), disp_hour(1));

    // simultaneous mode and inc: mode wins
    cyc(0, 1, 1, 1);
    cyc(0, 1, 1, 1);
    repeat (3) cyc(0, 1, 0, 0);
    chk("both_mode", int'(mode), 2);
    chk("both_hours", int'(hours), disp_hour(1));

    // reset during SET_MIN
    repeat (37) press(0, 1);
    chk("pre_rst_min", int'(minutes), 37);
    cyc(1, 1, 1, 1);
    chk("rst_hours", int'(hours), disp_hour(0));
    chk("rst_min", int'(minutes), 0);
    chk("rst_sec", int'(seconds), 0);
    chk("rst_tick", int'(sec_tick), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_pm", int'(pm), 0);

    // ena low at prescaler 2 with btn_mode pulsed
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 20; k++) begin
      cyc(0, 0, (k >= 2 && k < 6), 0);
      chk("ena_low_mode", int'(mode), 0);
      chk("ena_low_tick", int'(sec_tick), 0);
    end
    cyc(0, 1, 0, 0);
    chk("ena_back_tick1", int'(sec_tick), 0);
    cyc(0, 1, 0, 0);
    chk("ena_back_tick2", int'(sec_tick), 1);
    chk("ena_back_sec", int'(seconds), 1);
    repeat (4) cyc(0, 1, 0, 0);
    chk("ena_no_replay", int'(mode), 0);

    // randomized traffic against the model
    rbm = 0; rbi = 0;
    repeat (3000) begin
      rr = ($urandom_range(0, 299) == 0);
      re = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) rbm = ~rbm;
      if ($urandom_range(0, 4) == 0) rbi = ~rbi;
      cyc(rr, re, rbm, rbi);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
